wb_fifo_bridge: RTL

Parametrised Wishbone-to-Wishbone FIFO bridge. It carries data words from one Wishbone master to another: the SDC DMA master writes and the CPU reads, or the reverse. It is the successor of the fixed-size `wb_fifo`. It adds configurable width and depth, wait-state flow control with timeout/error, a status register, a flush command and an optional level interrupt.

---
 rtl/wb_fifo_pkg.sv | 27 ++
 rtl/wb_fifo_bridge_if.sv | 20 ++
 rtl/wb_fifo_core.sv | 72 +++++++
 rtl/wb_fifo_bridge.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/wb_fifo_pkg.sv
// Shared constants and types for the Wishbone FIFO bridge: address decode,
// STATUS layout, flush command bit and the per-port handshake FSM states.
package wb_fifo_pkg;

  localparam int unsigned ADR_SEL_BIT  = 2;
  localparam logic        OFS_DATA     = 1'b0;
  localparam logic        OFS_STATUS   = 1'b1;

  localparam int unsigned ST_EMPTY_BIT = 0;
  localparam int unsigned ST_FULL_BIT  = 1;
  localparam int unsigned ST_LEVEL_LSB = 2;
  localparam int unsigned FLUSH_BIT    = 0;

  localparam int unsigned PORT_WR      = 0;
  localparam int unsigned PORT_RD      = 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} port_state_e;

  // Source of the read data presented during the response cycle.
  typedef enum logic [1:0] {R_ZERO, R_STATUS, R_MEM} resp_src_e;

  // The IRQ flag sits just above the level field.
  function automatic int unsigned st_irq_bit(input int unsigned aw);
    return aw + 3;
  endfunction

endpackage

// File: rtl/wb_fifo_bridge_if.sv
// Wishbone slave-side bundle for one bridge port; signal directions are
// named from the bridge's (slave's) point of view.
interface wb_fifo_bridge_if #(
  parameter int unsigned DW = 32
);
  logic [DW-1:0]   dat_i;
  logic [DW-1:0]   dat_o;
  logic [31:0]     adr_i;
  logic [DW/8-1:0] sel_i;
  logic            we_i;
  logic            cyc_i;
  logic            stb_i;
  logic            ack_o;
  logic            err_o;

  modport slave  (input  dat_i, adr_i, sel_i, we_i, cyc_i, stb_i,
                  output dat_o, ack_o, err_o);
  modport master (output dat_i, adr_i, sel_i, we_i, cyc_i, stb_i,
                  input  dat_o, ack_o, err_o);
endinterface

// File: rtl/wb_fifo_core.sv
// FIFO storage for the bridge: DEPTH x DW RAM with registered read, wrapping
// pointers and an AW+1 bit level counter. Flush overrides push and pop.
module wb_fifo_core #(
  parameter  int unsigned DW    = 32,
  parameter  int unsigned DEPTH = 512,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic [AW:0]   level_o,
  output logic [AW:0]   level_nxt_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the RAM and its read register carry no reset so they map onto block RAM;
  // nothing downstream looks at them until a pop has loaded rdata_q.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    if (pop_i)  rdata_q         <= mem_q[rd_ptr_q];
  end

  assign rdata_o     = rdata_q;
  assign level_o     = level_q;
  assign level_nxt_o = level_d;
  assign full_o      = (level_q == (AW+1)'(DEPTH));
  assign empty_o     = (level_q == '0);

endmodule

// File: rtl/wb_fifo_bridge.sv
// Wishbone-to-Wishbone FIFO bridge: write port pushes, read port pops, each
// with an IDLE/WAIT/RESP handshake FSM. Optional level IRQ: WB_FIFO_BRIDGE_IRQ_EN.
module wb_fifo_bridge
  import wb_fifo_pkg::*;
#(
  parameter int unsigned DW         = 32,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned IRQ_THRESH = DEPTH / 2
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  wb_fifo_bridge_if.slave wr,
  wb_fifo_bridge_if.slave rd,
  output logic       irq_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]    cyc, stb, we, is_status, sel_ok, ack, err, go, flush_req;
  logic [DW-1:0] din  [2];
  logic [DW-1:0] dout [2];
  logic [DW-1:0] rdata, status;
  logic [AW:0]   level, level_nxt;
  logic          full, empty, irq_q;

  assign cyc       = {rd.cyc_i, wr.cyc_i};
  assign stb       = {rd.stb_i, wr.stb_i};
  assign we        = {rd.we_i,  wr.we_i};
  assign is_status = {rd.adr_i[ADR_SEL_BIT] == OFS_STATUS, wr.adr_i[ADR_SEL_BIT] == OFS_STATUS};
  assign sel_ok    = {&rd.sel_i, &wr.sel_i};
  assign din[0]    = wr.dat_i;
  assign din[1]    = rd.dat_i;

  wb_fifo_core #(.DW(DW), .DEPTH(DEPTH)) u_core (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .push_i      (go[PORT_WR]),
    .pop_i       (go[PORT_RD]),
    .flush_i     (flush_req[PORT_WR]),
    .wdata_i     (din[PORT_WR]),
    .rdata_o     (rdata),
    .level_o     (level),
    .level_nxt_o (level_nxt),
    .full_o      (full),
    .empty_o     (empty)
  );

  always_comb begin
    status                            = '0;
    status[ST_EMPTY_BIT]              = empty;
    status[ST_FULL_BIT]               = full;
    status[ST_LEVEL_LSB +: AW+1]      = level;
    status[st_irq_bit(AW)]            = irq_q;
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    port_state_e   state_q, state_d;
    resp_src_e     src_q, src_d;
    logic          err_q, err_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          go_l, flush_l, ready;

    // Blocking accesses only ever wait on the registered full/empty flags.
    assign ready = (p == PORT_WR) ? !full : !empty;

    always_comb begin
      state_d = state_q;
      src_d   = src_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      go_l    = 1'b0;
      flush_l = 1'b0;
      unique case (state_q)
        S_IDLE: if (cyc[p] && stb[p] && !ack[p] && !err[p]) begin
          state_d = S_RESP;
          src_d   = R_ZERO;
          err_d   = 1'b0;
          cnt_d   = '0;
          if (is_status[p]) begin
            if (!we[p])             src_d   = R_STATUS;
            else if (p == PORT_WR)  flush_l = din[p][FLUSH_BIT];
          end else if (we[p] && p == PORT_WR) begin
            if (!sel_ok[p])         err_d   = 1'b1;
            else if (ready)         go_l    = 1'b1;
            else                    state_d = S_WAIT;
          end else if (!we[p] && p == PORT_RD) begin
            src_d = R_MEM;
            if (ready)              go_l    = 1'b1;
            else                    state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (!cyc[p]) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (ready) begin
            go_l    = 1'b1;
            state_d = S_RESP;
          end else if (TIMEOUT != 0 && cnt_q == TW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end
        S_RESP:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        state_q <= S_IDLE;
        src_q   <= R_ZERO;
        err_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        src_q   <= src_d;
        err_q   <= err_d;
        cnt_q   <= cnt_d;
      end
    end

    assign go[p]        = go_l;
    assign flush_req[p] = flush_l;
    assign ack[p]       = (state_q == S_RESP) && !err_q;
    assign err[p]       = (state_q == S_RESP) && err_q;
    assign dout[p]      = !ack[p]            ? '0     :
                          (src_q == R_MEM)    ? rdata  :
                          (src_q == R_STATUS) ? status : '0;
  end

  assign wr.ack_o = ack[PORT_WR];
  assign wr.err_o = err[PORT_WR];
  assign wr.dat_o = dout[PORT_WR];
  assign rd.ack_o = ack[PORT_RD];
  assign rd.err_o = err[PORT_RD];
  assign rd.dat_o = dout[PORT_RD];

`ifdef WB_FIFO_BRIDGE_IRQ_EN
  // Tracks the next level so the flag moves together with the level it describes.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) irq_q <= 1'b0;
    else          irq_q <= (level_nxt >= (AW+1)'(IRQ_THRESH));
  end
  logic unused_sig;
  assign unused_sig = ^{wr.adr_i[31:3], wr.adr_i[1:0], rd.adr_i[31:3], rd.adr_i[1:0], flush_req[PORT_RD]};
`else
  assign irq_q = 1'b0;
  logic unused_sig;
  assign unused_sig = ^{wr.adr_i[31:3], wr.adr_i[1:0], rd.adr_i[31:3], rd.adr_i[1:0],
                        flush_req[PORT_RD], level_nxt};
`endif

  assign irq_o = irq_q;

endmodule
